// File: rtl/dp_pkg.sv
// ---------------------------------------------------------------------------
// dp_pkg
// Shared definitions for the DotProductSt inference sequencer:
//   - default datapath geometry (neurons, pixels, lanes, bus width, value width)
//   - derived chunk count per image
//   - width helper that never returns zero
//   - sequencer state encoding
// ---------------------------------------------------------------------------
package dp_pkg;

   localparam int NEURONS_DEF      = 10;
   localparam int PIXEL_N_DEF      = 785;
   localparam int PARALLEL_DEF     = 4;
   localparam int BUS_WIDTH_DEF    = 28;
   localparam int VAL_SIZE_DEF     = 26;
   localparam int DRAIN_CYCLES_DEF = 16;

   // Counter/select width; a one-entry range still needs a 1-bit signal.
   function automatic int clog2w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Chunks needed to cover one image; the memories zero-pad the tail chunk.
   function automatic int chunks_of(input int pixel_n, input int parallel, input int bus_width);
      return (pixel_n + parallel * bus_width - 1) / (parallel * bus_width);
   endfunction

   localparam int CHUNKS_DEF = chunks_of(PIXEL_N_DEF, PARALLEL_DEF, BUS_WIDTH_DEF);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_FEED    = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_CAPTURE = 3'd4,
      ST_DONE    = 3'd5
   } seq_state_t;

endpackage

// File: rtl/dp_sequencer_if.sv
// ---------------------------------------------------------------------------
// dp_sequencer_if
// Bundle between the sequencer and its environment (host control, pixel/weight
// memories, DotProductSt datapath).
//   start       host -> seq   one-cycle inference request
//   busy, done  seq  -> host  status / one-cycle completion pulse
//   class_out   seq  -> host  winning neuron index
//   class_value seq  -> host  winning dot-product value
//   dp_reset    seq  -> dp    active-high datapath clear
//   dp_value    dp   -> seq   datapath dot-product output (signed)
//   neuron_sel  seq  -> mem   weight bank select
//   chunk_addr  seq  -> mem   chunk index
//   feed_valid  seq  -> mem   chunk_addr is being streamed
// master = sequencer side, slave = environment side.
// ---------------------------------------------------------------------------
interface dp_sequencer_if import dp_pkg::*; #(
   parameter int NEURONS  = NEURONS_DEF,
   parameter int CHUNKS   = CHUNKS_DEF,
   parameter int VAL_SIZE = VAL_SIZE_DEF
) ();

   localparam int SEL_W  = clog2w(NEURONS);
   localparam int ADDR_W = clog2w(CHUNKS);

   logic                start;
   logic                busy;
   logic                done;
   logic                dp_reset;
   logic                feed_valid;
   logic [SEL_W-1:0]    neuron_sel;
   logic [SEL_W-1:0]    class_out;
   logic [ADDR_W-1:0]   chunk_addr;
   logic [VAL_SIZE-1:0] dp_value;
   logic [VAL_SIZE-1:0] class_value;

   modport master (
      input  start, dp_value,
      output busy, done, dp_reset, feed_valid, neuron_sel, class_out, chunk_addr, class_value
   );

   modport slave (
      output start, dp_value,
      input  busy, done, dp_reset, feed_valid, neuron_sel, class_out, chunk_addr, class_value
   );

endinterface

// File: rtl/dp_sequencer_argmax_tracker.sv
// ---------------------------------------------------------------------------
// argmax_tracker
// Running signed maximum over captured dot-product values.
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        start of an inference: max <- most negative, arg <- 0
//   load         capture cycle: fold value/index into the running max
//   value/index  candidate value and its neuron index
//   best_value/best_index
//                running result including the capture in progress, so the
//                caller can register the final answer on the last capture edge
// Strictly-greater compare: on a tie the earlier (lower) index is kept.
// ---------------------------------------------------------------------------
module argmax_tracker import dp_pkg::*; #(
   parameter int VAL_SIZE = VAL_SIZE_DEF,
   parameter int IDX_W    = clog2w(NEURONS_DEF)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic                load,
   input  logic [VAL_SIZE-1:0] value,
   input  logic [IDX_W-1:0]    index,
   output logic [VAL_SIZE-1:0] best_value,
   output logic [IDX_W-1:0]    best_index
);

   localparam logic [VAL_SIZE-1:0] MOST_NEG = {1'b1, {(VAL_SIZE-1){1'b0}}};

   logic [VAL_SIZE-1:0] max_reg;
   logic [IDX_W-1:0]    arg_reg;
   logic                take;

   assign take       = load && ($signed(value) > $signed(max_reg));
   assign best_value = take ? value : max_reg;
   assign best_index = take ? index : arg_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_reg <= '0;
         arg_reg <= '0;
      end else if (clear) begin
         max_reg <= MOST_NEG;
         arg_reg <= '0;
      end else if (load) begin
         max_reg <= best_value;
         arg_reg <= best_index;
      end
   end

endmodule

// File: rtl/dp_sequencer.sv
// ---------------------------------------------------------------------------
// dp_sequencer
// Runs one inference over the DotProductSt datapath: for every neuron it clears
// the datapath, streams CHUNKS chunks of BUS_WIDTH beats, waits DRAIN_CYCLES
// for the pipeline to settle and captures dp_value into a running argmax.
//   clk          clock
//   GlobalReset  asynchronous active-low reset
//   bus          dp_sequencer_if.master (control, memory and datapath signals)
// Per neuron: CLEAR(1) + FEED(CHUNKS*BUS_WIDTH) + DRAIN(DRAIN_CYCLES) + CAPTURE(1).
// class_out/class_value are registered on the final capture edge so they are
// already valid while done is high, and otherwise hold between inferences.
// ---------------------------------------------------------------------------
module dp_sequencer import dp_pkg::*; #(
   parameter int NEURONS      = NEURONS_DEF,
   parameter int PIXEL_N      = PIXEL_N_DEF,
   parameter int PARALLEL     = PARALLEL_DEF,
   parameter int BUS_WIDTH    = BUS_WIDTH_DEF,
   parameter int VAL_SIZE     = VAL_SIZE_DEF,
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
   input  logic            clk,
   input  logic            GlobalReset,
   dp_sequencer_if.master  bus
);

   localparam int CHUNKS  = chunks_of(PIXEL_N, PARALLEL, BUS_WIDTH);
   localparam int SEL_W   = clog2w(NEURONS);
   localparam int ADDR_W  = clog2w(CHUNKS);
   localparam int BEAT_W  = clog2w(BUS_WIDTH);
   localparam int DRAIN_W = clog2w(DRAIN_CYCLES);

   localparam logic [SEL_W-1:0]   NEURON_LAST = SEL_W'(NEURONS - 1);
   localparam logic [ADDR_W-1:0]  CHUNK_LAST  = ADDR_W'(CHUNKS - 1);
   localparam logic [BEAT_W-1:0]  BEAT_LAST   = BEAT_W'(BUS_WIDTH - 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST  = DRAIN_W'(DRAIN_CYCLES - 1);

   seq_state_t          state_reg, state_next;
   logic [SEL_W-1:0]    neuron_reg, neuron_next;
   logic [ADDR_W-1:0]   chunk_reg, chunk_next;
   logic [BEAT_W-1:0]   beat_reg, beat_next;
   logic [DRAIN_W-1:0]  drain_reg, drain_next;
   logic [SEL_W-1:0]    class_out_reg;
   logic [VAL_SIZE-1:0] class_value_reg;

   logic                start_accept;
   logic                capture;
   logic                last_neuron;
   logic [VAL_SIZE-1:0] best_value;
   logic [SEL_W-1:0]    best_index;

   assign start_accept = (state_reg == ST_IDLE) && bus.start;
   assign capture      = (state_reg == ST_CAPTURE);
   assign last_neuron  = (neuron_reg == NEURON_LAST);

   argmax_tracker #(
      .VAL_SIZE (VAL_SIZE),
      .IDX_W    (SEL_W)
   ) u_argmax (
      .clk        (clk),
      .rst_n      (GlobalReset),
      .clear      (start_accept),
      .load       (capture),
      .value      (bus.dp_value),
      .index      (neuron_reg),
      .best_value (best_value),
      .best_index (best_index)
   );

   always_ff @(posedge clk or negedge GlobalReset) begin
      if (!GlobalReset) begin
         state_reg       <= ST_IDLE;
         neuron_reg      <= '0;
         chunk_reg       <= '0;
         beat_reg        <= '0;
         drain_reg       <= '0;
         class_out_reg   <= '0;
         class_value_reg <= '0;
      end else begin
         state_reg  <= state_next;
         neuron_reg <= neuron_next;
         chunk_reg  <= chunk_next;
         beat_reg   <= beat_next;
         drain_reg  <= drain_next;
         if (capture && last_neuron) begin
            class_out_reg   <= best_index;
            class_value_reg <= best_value;
         end
      end
   end

   always_comb begin
      state_next  = state_reg;
      neuron_next = neuron_reg;
      chunk_next  = chunk_reg;
      beat_next   = beat_reg;
      drain_next  = drain_reg;
      case (state_reg)
         ST_IDLE: begin
            if (bus.start) begin
               state_next  = ST_CLEAR;
               neuron_next = '0;
               chunk_next  = '0;
            end
         end
         ST_CLEAR: begin
            state_next = ST_FEED;
            beat_next  = '0;
            chunk_next = '0;
         end
         ST_FEED: begin
            if (beat_reg == BEAT_LAST) begin
               beat_next = '0;
               if (chunk_reg == CHUNK_LAST) begin
                  // Last chunk stays on the bus address; memories are ignored in DRAIN.
                  state_next = ST_DRAIN;
                  drain_next = '0;
               end else begin
                  chunk_next = chunk_reg + 1'b1;
               end
            end else begin
               beat_next = beat_reg + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (drain_reg == DRAIN_LAST) begin
               state_next = ST_CAPTURE;
            end else begin
               drain_next = drain_reg + 1'b1;
            end
         end
         ST_CAPTURE: begin
            if (last_neuron) begin
               state_next = ST_DONE;
            end else begin
               state_next  = ST_CLEAR;
               neuron_next = neuron_reg + 1'b1;
               chunk_next  = '0;
            end
         end
         ST_DONE: begin
            state_next  = ST_IDLE;
            neuron_next = '0;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Moore outputs; the datapath stays cleared whenever no neuron is in flight.
   assign bus.busy        = (state_reg != ST_IDLE);
   assign bus.done        = (state_reg == ST_DONE);
   assign bus.dp_reset    = (state_reg == ST_IDLE) || (state_reg == ST_CLEAR);
   assign bus.feed_valid  = (state_reg == ST_FEED);
   assign bus.neuron_sel  = neuron_reg;
   assign bus.chunk_addr  = chunk_reg;
   assign bus.class_out   = class_out_reg;
   assign bus.class_value = class_value_reg;

endmodule

// File: tb/tb_dp_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dp_sequencer
// Small configuration: 3 neurons, 4-beat bus, 2 chunks, 5 drain cycles.
// The datapath is modelled by returning a fixed value per neuron_sel; the
// expected winner is found by taking the maximum first and then the lowest
// index holding it. Cycle timing is derived from the per-neuron schedule.
// ---------------------------------------------------------------------------
module tb_dp_sequencer;
   import dp_pkg::*;

   localparam int N   = 3;
   localparam int BW  = 4;
   localparam int PAR = 4;
   localparam int PIX = 30;
   localparam int CH  = 2;
   localparam int DR  = 5;
   localparam int VS  = 26;
   localparam int PER = 2 + CH * BW + DR;   // 15 cycles per neuron
   localparam int LAT = N * PER;            // 45

   logic clk;
   logic global_reset;

   int tests;
   int fails;

   logic signed [VS-1:0] vals [4];
   logic [1:0]           prev_idx;
   logic [VS-1:0]        prev_max;

   dp_sequencer_if #(.NEURONS(N), .CHUNKS(CH), .VAL_SIZE(VS)) bus ();

   dp_sequencer #(
      .NEURONS      (N),
      .PIXEL_N      (PIX),
      .PARALLEL     (PAR),
      .BUS_WIDTH    (BW),
      .VAL_SIZE     (VS),
      .DRAIN_CYCLES (DR)
   ) dut (
      .clk         (clk),
      .GlobalReset (global_reset),
      .bus         (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.dp_value = vals[bus.neuron_sel];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_vals(input int a, input int b, input int c);
      vals[0] = VS'(a);
      vals[1] = VS'(b);
      vals[2] = VS'(c);
      vals[3] = '0;
   endtask

   // Maximum value first, then the lowest index that carries it.
   task automatic model_result(output logic [1:0] idx, output logic [VS-1:0] mx);
      logic signed [VS-1:0] m;
      m = vals[0];
      for (int i = 1; i < N; i++) m = (vals[i] > m) ? vals[i] : m;
      idx = 2'd0;
      for (int i = N - 1; i >= 0; i--) if (vals[i] == m) idx = 2'(i);
      mx = m;
   endtask

   task automatic run_inference(input int repulse_at, input int reset_at);
      logic [1:0]    exp_idx;
      logic [VS-1:0] exp_max;
      int dones;
      int p;
      int n;
      model_result(exp_idx, exp_max);
      dones = 0;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      for (int e = 0; e <= LAT + 5; e++) begin
         if (e > 0) begin
            @(posedge clk);
            #1;
         end
         if (e == repulse_at) bus.start = 1'b0;
         if (bus.done === 1'b1) dones++;
         p = e % PER;
         n = e / PER;
         if (e < LAT) begin
            check("busy", {31'b0, bus.busy}, 1);
            check("done_early", {31'b0, bus.done}, 0);
            check("feed_valid", {31'b0, bus.feed_valid}, (p >= 1 && p <= CH * BW) ? 1 : 0);
            check("dp_reset", {31'b0, bus.dp_reset}, (p == 0) ? 1 : 0);
            check("neuron_sel", {30'b0, bus.neuron_sel}, n);
            if (p >= 1 && p <= CH * BW)
               check("chunk_addr", {31'b0, bus.chunk_addr}, (p - 1) / BW);
            check("class_out_hold", {30'b0, bus.class_out}, {30'b0, prev_idx});
            check("class_value_hold", {6'b0, bus.class_value}, {6'b0, prev_max});
         end else begin
            check("busy_end", {31'b0, bus.busy}, (e == LAT) ? 1 : 0);
            check("done", {31'b0, bus.done}, (e == LAT) ? 1 : 0);
            check("feed_valid_end", {31'b0, bus.feed_valid}, 0);
            if (e > LAT) check("dp_reset_idle", {31'b0, bus.dp_reset}, 1);
            check("class_out", {30'b0, bus.class_out}, {30'b0, exp_idx});
            check("class_value", {6'b0, bus.class_value}, {6'b0, exp_max});
         end
         if (e == reset_at) begin
            global_reset = 1'b0;
            #2;
            check("rst_busy", {31'b0, bus.busy}, 0);
            check("rst_done", {31'b0, bus.done}, 0);
            check("rst_dp_reset", {31'b0, bus.dp_reset}, 1);
            check("rst_feed_valid", {31'b0, bus.feed_valid}, 0);
            check("rst_class_out", {30'b0, bus.class_out}, 0);
            check("rst_class_value", {6'b0, bus.class_value}, 0);
            prev_idx = '0;
            prev_max = '0;
            @(negedge clk);
            global_reset = 1'b1;
            $display("[TB] inference aborted by reset at cycle %0d", e);
            return;
         end
         if (e + 1 == repulse_at) bus.start = 1'b1;
      end
      check("done_pulses", dones, 1);
      prev_idx = exp_idx;
      prev_max = exp_max;
      $display("[TB] inference vals=%0d,%0d,%0d repulse=%0d class_out=%0d class_value=%0d",
               vals[0], vals[1], vals[2], repulse_at, bus.class_out, $signed(bus.class_value));
   endtask

   initial begin
      int t;
      tests        = 0;
      fails        = 0;
      prev_idx     = '0;
      prev_max     = '0;
      bus.start    = 1'b0;
      global_reset = 1'b0;
      set_vals(0, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", {31'b0, bus.busy}, 0);
      check("reset_done", {31'b0, bus.done}, 0);
      check("reset_dp_reset", {31'b0, bus.dp_reset}, 1);
      check("reset_feed_valid", {31'b0, bus.feed_valid}, 0);
      check("reset_neuron_sel", {30'b0, bus.neuron_sel}, 0);
      check("reset_chunk_addr", {31'b0, bus.chunk_addr}, 0);
      check("reset_class_out", {30'b0, bus.class_out}, 0);
      check("reset_class_value", {6'b0, bus.class_value}, 0);
      @(negedge clk);
      global_reset = 1'b1;
      $display("[TB] reset released");

      set_vals(100, -50, 300);
      run_inference(-1, -1);
      set_vals(7, 7, -1);
      run_inference(-1, -1);
      set_vals(-9, -3, -4);
      run_inference(-1, -1);
      set_vals(5, 20, 20);
      run_inference(10, -1);
      set_vals(1, 2, 3);
      run_inference(-1, 20);
      set_vals(-1000, 4000, -7);
      run_inference(-1, -1);

      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < N; i++) begin
            if (k[0]) begin
               t = int'($urandom_range(0, 6)) - 3;
               vals[i] = VS'(t);
            end else begin
               vals[i] = VS'($urandom());
            end
         end
         run_inference(-1, -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
- Top-level controller for the DotProductSt datapath. It sequences one inference: for each of NEURONS neurons, it clears the datapath, streams pixel/weight bus chunks, waits out the pipeline and captures the dot-product value.
- Keeps a running signed maximum over the captured values and reports the winning class index.
- Sits between the pixel/weight memories (drives chunk address and neuron select) and the DotProductSt instance (drives its reset, reads its value).

Parameters:
- NEURONS, 10, number of output neurons (classes).
- PIXEL_N, 785, pixels per image including bias term.
- PARALLEL, 4, datapath lanes.
- BUS_WIDTH, 28, elements per lane per chunk. Equals the datapath width_cnt period.
- VAL_SIZE, 26, datapath value width, signed two's complement.
- DRAIN_CYCLES, 16, cycles from the last chunk cycle until dp_value is final.
- CHUNKS, derived constant = ceil(PIXEL_N/(PARALLEL*BUS_WIDTH)) = 8 by default. Memory zero-pads the tail.

Ports:
- clk  in  1  clock.
- GlobalReset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin an inference.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the result is valid.
- dp_reset  out  1  active-high reset to the DotProductSt GlobalReset.
- neuron_sel  out  clog2(NEURONS)  neuron whose weights memory must present.
- chunk_addr  out  clog2(CHUNKS)  chunk index for pixel/weight memories.
- feed_valid  out  1  high while chunk_addr is being streamed.
- dp_value  in  VAL_SIZE  DotProductSt value output.
- class_out  out  clog2(NEURONS)  argmax index, held until the next start.
- class_value  out  VAL_SIZE  maximum value, held until the next start.

Behaviour:
- Reset (GlobalReset=0, async): state=IDLE. All counters 0. busy=0, done=0, feed_valid=0, dp_reset=1 (datapath held cleared), neuron_sel=0, chunk_addr=0, class_out=0, class_value=0.
- FSM states: IDLE, CLEAR, FEED, DRAIN, CAPTURE, DONE.
- IDLE:
  - dp_reset=1.
  - start=1 → CLEAR; neuron_sel=0; max register loaded with the most-negative VAL_SIZE value.
- CLEAR: exactly 1 cycle, dp_reset=1, which resets the datapath width_cnt/cnt3 alignment. Next state FEED with beat=0 and chunk_addr=0.
- FEED:
  - dp_reset=0, feed_valid=1.
  - beat counts 0..BUS_WIDTH-1. At beat==BUS_WIDTH-1, chunk_addr increments.
  - After chunk CHUNKS-1, beat BUS_WIDTH-1 → DRAIN.
  - Duration exactly CHUNKS*BUS_WIDTH cycles.
- DRAIN: feed_valid=0, memories return zeros. Counts DRAIN_CYCLES cycles → CAPTURE.
- CAPTURE (1 cycle):
  - Signed compare: if dp_value > max (strictly greater), then max=dp_value and arg=neuron_sel. Ties keep the lower index.
  - If neuron_sel==NEURONS-1 → DONE. Otherwise neuron_sel+1 → CLEAR.
- DONE (1 cycle): done=1; class_out/class_value register arg/max → IDLE.
- busy=1 in every state except IDLE.
- Latency: start sampled at edge 0 gives done high for the cycle after edge NEURONS*(2+CHUNKS*BUS_WIDTH+DRAIN_CYCLES). Default: 10*(2+224+16)=2420.
- start while busy is ignored. No queuing.
- Reset mid-operation aborts immediately. class_out/class_value return to 0. The next start runs a full inference.
- class_out/class_value are unchanged during an inference. They update only in DONE.
- chunk_addr wraps to 0 on entry to CLEAR. It never exceeds CHUNKS-1.

Decomposition:
- Shared package dp_pkg: CLOG2 helper, default NEURONS/PIXEL_N/PARALLEL/BUS_WIDTH/VAL_SIZE, derived CHUNKS, state encoding constants.
- One sub-module argmax_tracker: signed compare, max/arg registers, clear-on-start, load-on-capture.

Test Plan:
- Small config (NEURONS=3, BUS_WIDTH=4, CHUNKS=2, DRAIN_CYCLES=5): pulse start → busy next cycle; done after 3*(2+8+5)=45 cycles; feed_valid high exactly 8 cycles per neuron with chunk_addr 0,0,0,0,1,1,1,1.
- dp_value model returns 100, -50, 300 for neurons 0,1,2 → class_out=2, class_value=300.
- Returns 7, 7, -1 → class_out=0 (tie keeps lower index), class_value=7. All negative (-9, -3, -4) → class_out=1, class_value=-3.
- start re-pulsed at cycle 10 of an inference → ignored; done still at cycle 45; exactly one done pulse.
- GlobalReset low at cycle 20 → busy=0, dp_reset=1, class_out=0, class_value=0 asynchronously; fresh start completes in 45 cycles.
- Default parameters with DotProductSt plus FPM/FPA instances, all-ones pixels and known weights → class_value matches the golden fixed-point sums; done at cycle 2420.
